// File: rtl/loader_pkg.sv
// Shared state encoding, default widths and stream-length helper for the instruction memory loader.
package loader_pkg;

   localparam int DEF_ADDR_W    = 15;
   localparam int DEF_INSTR_W   = 20;
   localparam int DEF_MAX_WORDS = 1024;
   localparam int LEN_W         = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_WRITE,
      ST_CHK,
      ST_DONE,
      ST_ERROR
   } loader_state_e;

   typedef logic [1:0] byte_idx_t;

   localparam byte_idx_t LAST_BYTE = 2'd2;

   // Bit 15 of the length field is reserved, so only LEN_HI[6:0] is passed in.
   function automatic logic [LEN_W-1:0] stream_len(input logic [6:0] hi, input logic [7:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/instr_byte_packer.sv
// Collects three little-endian stream bytes into one instruction word.
// word_ready_o/fmt_err_o are valid in the cycle the third byte is pushed.
module instr_byte_packer
   import loader_pkg::*;
#(
   parameter int INSTR_W = DEF_INSTR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_i,
   input  logic               push_i,
   input  logic [7:0]         byte_i,
   output logic [INSTR_W-1:0] word_o,
   output logic               word_ready_o,
   output logic               fmt_err_o
);

   byte_idx_t  idx_q;
   logic [7:0] b0_q;
   logic [7:0] b1_q;

   // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         idx_q <= '0;
         b0_q  <= '0;
         b1_q  <= '0;
      end else if (push_i) begin
         idx_q <= (idx_q == LAST_BYTE) ? '0 : idx_q + byte_idx_t'(1);
         if (idx_q == 2'd0) b0_q <= byte_i;
         if (idx_q == 2'd1) b1_q <= byte_i;
      end
   end

   // The third byte is used straight from the bus, so the word is ready without an extra cycle.
   assign word_ready_o = push_i && (idx_q == LAST_BYTE);
   assign fmt_err_o    = word_ready_o && (byte_i[7:4] != 4'h0);
   assign word_o       = INSTR_W'({byte_i[3:0], b1_q, b0_q});

endmodule

// File: rtl/instr_mem_loader.sv
// Writes a length-prefixed byte stream into instruction memory and holds the core meanwhile.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before reporting done.
module instr_mem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int INSTR_W   = DEF_INSTR_W,
   parameter int MAX_WORDS = DEF_MAX_WORDS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic               byte_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [ADDR_W-1:0]  words_written
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

   loader_state_e      state_q;
   logic [7:0]         len_lo_q;
   logic [ADDR_W-1:0]  len_q;
   logic [ADDR_W-1:0]  words_written_q;
   logic               imem_we_q;
   logic [ADDR_W-1:0]  imem_addr_q;
   logic [INSTR_W-1:0] imem_wdata_q;
   logic               busy_q;
   logic               cpu_hold_q;
   logic               done_q;
   logic               error_q;

   logic               xfer;
   logic               start_ok;
   logic               pk_push;
   logic               pk_word_ready;
   logic               pk_fmt_err;
   logic [INSTR_W-1:0] pk_word;
   logic [LEN_W-1:0]   len_in;

   assign byte_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                       (state_q == ST_DATA)   || (state_q == ST_CHK);
   assign xfer       = byte_valid && byte_ready;
   assign start_ok   = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
   assign pk_push    = xfer && (state_q == ST_DATA);
   assign len_in     = stream_len(byte_data[6:0], len_lo_q);

   instr_byte_packer #(.INSTR_W(INSTR_W)) u_packer (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (start_ok),
      .push_i       (pk_push),
      .byte_i       (byte_data),
      .word_o       (pk_word),
      .word_ready_o (pk_word_ready),
      .fmt_err_o    (pk_fmt_err)
   );

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum_q;

   // The checksum byte itself also gets folded in, but it is only compared before that update lands.
   always_ff @(posedge clk) begin
      if (reset || start_ok) csum_q <= '0;
      else if (xfer)         csum_q <= csum_q ^ byte_data;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         len_lo_q        <= '0;
         len_q           <= '0;
         words_written_q <= '0;
         imem_we_q       <= 1'b0;
         imem_addr_q     <= '0;
         imem_wdata_q    <= '0;
         busy_q          <= 1'b0;
         cpu_hold_q      <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         imem_we_q <= 1'b0;
         if (start_ok) begin
            state_q         <= ST_LEN_LO;
            busy_q          <= 1'b1;
            cpu_hold_q      <= 1'b1;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            words_written_q <= '0;
         end else begin
            case (state_q)
               ST_LEN_LO: begin
                  if (xfer) begin
                     len_lo_q <= byte_data;
                     state_q  <= ST_LEN_HI;
                  end
               end
               ST_LEN_HI: begin
                  if (xfer) begin
                     len_q <= ADDR_W'(len_in);
                     if (len_in == '0) begin
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        cpu_hold_q <= 1'b0;
                        done_q     <= 1'b1;
                     end else if (len_in > MAX_LEN) begin
                        state_q <= ST_ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                     end else begin
                        state_q <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  if (pk_fmt_err) begin
                     state_q <= ST_ERROR;
                     busy_q  <= 1'b0;
                     error_q <= 1'b1;
                  end else if (pk_word_ready) begin
                     state_q         <= ST_WRITE;
                     imem_we_q       <= 1'b1;
                     imem_addr_q     <= words_written_q;
                     imem_wdata_q    <= pk_word;
                     words_written_q <= words_written_q + ADDR_W'(1);
                  end
               end
               ST_WRITE: begin
                  // words_written_q already counts the word being written this cycle.
                  if (words_written_q == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                     state_q <= ST_CHK;
`else
                     state_q    <= ST_DONE;
                     busy_q     <= 1'b0;
                     cpu_hold_q <= 1'b0;
                     done_q     <= 1'b1;
`endif
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               ST_CHK: begin
                  if (xfer) begin
                     busy_q <= 1'b0;
                     if (byte_data == csum_q) begin
                        state_q    <= ST_DONE;
                        cpu_hold_q <= 1'b0;
                        done_q     <= 1'b1;
                     end else begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                     end
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign imem_we       = imem_we_q;
   assign imem_addr     = imem_addr_q;
   assign imem_wdata    = imem_wdata_q;
   assign busy          = busy_q;
   assign cpu_hold      = cpu_hold_q;
   assign done          = done_q;
   assign error         = error_q;
   assign words_written = words_written_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: per-cycle vector table plus multi-cycle stream sequences.
// Follows LOADER_CHECKSUM_EN the same way the design does.
module tb_instr_mem_loader;

   localparam int ADDR_W    = 15;
   localparam int INSTR_W   = 20;
   localparam int MAX_WORDS = 1024;

   // Flag order: {byte_ready, imem_we, busy, cpu_hold, done, error}
   localparam logic [5:0] F_ACC  = 6'b101100;
   localparam logic [5:0] F_WR   = 6'b011100;
   localparam logic [5:0] F_DONE = 6'b000010;
   localparam logic [5:0] F_ERR  = 6'b000101;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               byte_valid;
   logic [7:0]         byte_data;
   logic               byte_ready;
   logic               imem_we;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_wdata;
   logic               cpu_hold;
   logic               busy;
   logic               done;
   logic               error;
   logic [ADDR_W-1:0]  words_written;

   instr_mem_loader #(
      .ADDR_W    (ADDR_W),
      .INSTR_W   (INSTR_W),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .imem_we       (imem_we),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .cpu_hold      (cpu_hold),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string      name;
      logic       start;
      logic       valid;
      logic [7:0] data;
      logic [5:0] flags;
      logic [14:0] ww;
      logic [14:0] addr;
      logic [19:0] wd;
   } vec_t;

   vec_t        tbl[$];
   logic [34:0] wr_q[$];
   logic [7:0]  stream[$];

   // Write log sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] snap();
      return {8'h00, byte_ready, imem_we, busy, cpu_hold, done, error, words_written, imem_addr, imem_wdata};
   endfunction

   function automatic void add(input string nm, input logic s, input logic v, input logic [7:0] d,
                               input logic [5:0] f, input int ww, input int addr, input int wd);
      vec_t e;
      e.name  = nm;
      e.start = s;
      e.valid = v;
      e.data  = d;
      e.flags = f;
      e.ww    = 15'(ww);
      e.addr  = 15'(addr);
      e.wd    = 20'(wd);
      tbl.push_back(e);
   endfunction

   task automatic cycle(input logic s, input logic v, input logic [7:0] d);
      start      = s;
      byte_valid = v;
      byte_data  = d;
      @(posedge clk);
      #1;
   endtask

   // Sends the bytes in 'stream' after a start pulse; optional random gaps and an ignored mid-load start.
   task automatic run_stream(input string tag, input bit gaps);
      int budget;
      cycle(1'b1, 1'b0, 8'h00);
      start = 1'b0;
      for (int i = 0; i < stream.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 8'h00);
         end
         byte_valid = 1'b1;
         byte_data  = stream[i];
         budget     = 20;
         while (!byte_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
         end
         if (!byte_ready) begin
            check({tag, "_ready_timeout"}, 64'(byte_ready), 64'd1);
            byte_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         byte_valid = 1'b0;
         if (gaps && i == 3) begin
            cycle(1'b1, 1'b0, 8'h00);
            start = 1'b0;
            check({tag, "_mid_start_ignored"}, 64'({busy, cpu_hold, done, error}), 64'(4'b1100));
         end
      end
      budget = 20;
      while (!done && !error && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      check({tag, "_finished"}, 64'(done | error), 64'd1);
   endtask

   task automatic check_three_words(input string tag, input int base);
      logic [34:0] exp_w[3];
      exp_w[0] = {15'd0, 20'h32211};
      exp_w[1] = {15'd1, 20'h65544};
      exp_w[2] = {15'd2, 20'h98877};
      check({tag, "_status"}, 64'({done, error, cpu_hold, busy, words_written}), 64'({4'b1000, 15'd3}));
      check({tag, "_nwrites"}, 64'(wr_q.size() - base), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (base + i < wr_q.size())
            check($sformatf("%s_write%0d", tag, i), 64'(wr_q[base + i]), 64'(exp_w[i]));
      end
   endtask

   initial begin
      int base;

      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", snap(), 64'h0);
      reset = 1'b0;

      // A: len=2, two words.
      add("A_start", 1, 0, 8'h00, F_ACC, 0, 0, 0);
      add("A_lenlo", 0, 1, 8'h02, F_ACC, 0, 0, 0);
      add("A_lenhi", 0, 1, 8'h00, F_ACC, 0, 0, 0);
      add("A_w0b0",  0, 1, 8'h34, F_ACC, 0, 0, 0);
      add("A_w0b1",  0, 1, 8'h12, F_ACC, 0, 0, 0);
      add("A_w0b2",  0, 1, 8'h05, F_WR,  1, 0, 'h51234);
      add("A_gap",   0, 0, 8'h00, F_ACC, 1, 0, 'h51234);
      add("A_w1b0",  0, 1, 8'hCD, F_ACC, 1, 0, 'h51234);
      add("A_w1b1",  0, 1, 8'hAB, F_ACC, 1, 0, 'h51234);
      add("A_w1b2",  0, 1, 8'h0F, F_WR,  2, 1, 'hFABCD);
`ifdef LOADER_CHECKSUM_EN
      add("A_chk",   0, 0, 8'h00, F_ACC,  2, 1, 'hFABCD);
      add("A_done",  0, 1, 8'h48, F_DONE, 2, 1, 'hFABCD);
`else
      add("A_done",  0, 0, 8'h00, F_DONE, 2, 1, 'hFABCD);
`endif
      // B: len=0 finishes two transfers after start.
      add("B_start", 1, 0, 8'h00, F_ACC,  0, 1, 'hFABCD);
      add("B_lenlo", 0, 1, 8'h00, F_ACC,  0, 1, 'hFABCD);
      add("B_done",  0, 1, 8'h00, F_DONE, 0, 1, 'hFABCD);
      // C: upper nibble of b2 set -> error, no write; restart clears it.
      add("C_start", 1, 0, 8'h00, F_ACC, 0, 1, 'hFABCD);
      add("C_lenlo", 0, 1, 8'h01, F_ACC, 0, 1, 'hFABCD);
      add("C_lenhi", 0, 1, 8'h00, F_ACC, 0, 1, 'hFABCD);
      add("C_b0",    0, 1, 8'hAA, F_ACC, 0, 1, 'hFABCD);
      add("C_b1",    0, 1, 8'hBB, F_ACC, 0, 1, 'hFABCD);
      add("C_b2bad", 0, 1, 8'h1F, F_ERR, 0, 1, 'hFABCD);
      add("C_stay",  0, 1, 8'h00, F_ERR, 0, 1, 'hFABCD);
      add("C_restart", 1, 0, 8'h00, F_ACC, 0, 1, 'hFABCD);
      // D: len=MAX_WORDS+1 -> error after LEN_HI, no further acceptance.
      add("D_lenlo", 0, 1, 8'h01, F_ACC, 0, 1, 'hFABCD);
      add("D_lenhi", 0, 1, 8'h04, F_ERR, 0, 1, 'hFABCD);
      add("D_stay0", 0, 1, 8'h00, F_ERR, 0, 1, 'hFABCD);
      add("D_stay1", 0, 1, 8'h00, F_ERR, 0, 1, 'hFABCD);
      // E: length bit 15 ignored -> len=0.
      add("E_start", 1, 0, 8'h00, F_ACC,  0, 1, 'hFABCD);
      add("E_lenlo", 0, 1, 8'h00, F_ACC,  0, 1, 'hFABCD);
      add("E_done",  0, 1, 8'h80, F_DONE, 0, 1, 'hFABCD);
      // F: len=MAX_WORDS is accepted; left in DATA for the reset sequence.
      add("F_start", 1, 0, 8'h00, F_ACC, 0, 1, 'hFABCD);
      add("F_lenlo", 0, 1, 8'h00, F_ACC, 0, 1, 'hFABCD);
      add("F_lenhi", 0, 1, 8'h04, F_ACC, 0, 1, 'hFABCD);
      add("F_stall", 0, 0, 8'h00, F_ACC, 0, 1, 'hFABCD);

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].start, tbl[i].valid, tbl[i].data);
         check(tbl[i].name, snap(),
               {8'h00, tbl[i].flags, tbl[i].ww, tbl[i].addr, tbl[i].wd});
      end
      start      = 1'b0;
      byte_valid = 1'b0;

      // Reset in the middle of a load.
      base = wr_q.size();
      cycle(1'b0, 1'b1, 8'h01);
      cycle(1'b0, 1'b1, 8'h02);
      cycle(1'b0, 1'b1, 8'h03);
      check("rst_pre_write", snap(), {8'h00, F_WR, 15'd1, 15'd0, 20'h30201});
      cycle(1'b0, 1'b1, 8'h44);
      cycle(1'b0, 1'b1, 8'h55);
      reset = 1'b1;
      cycle(1'b0, 1'b1, 8'h66);
      reset = 1'b0;
      check("rst_mid_clear", snap(), 64'h0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 8'h77);
         check($sformatf("rst_idle%0d", i), snap(), 64'h0);
      end
      check("rst_nwrites", 64'(wr_q.size() - base), 64'd1);
      byte_valid = 1'b0;

      // len=3 gap-free, then with random gaps and an ignored start.
      stream = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h06, 8'h77, 8'h88, 8'h09};
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(8'hD2);
`endif
      base = wr_q.size();
      run_stream("nogap", 1'b0);
      check_three_words("nogap", base);
      base = wr_q.size();
      run_stream("gap", 1'b1);
      check_three_words("gap", base);

`ifdef LOADER_CHECKSUM_EN
      stream = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      base = wr_q.size();
      run_stream("csum_ok", 1'b0);
      check("csum_ok_status", 64'({done, error, cpu_hold, busy}), 64'(4'b1000));
      check("csum_ok_nwrites", 64'(wr_q.size() - base), 64'd1);
      if (wr_q.size() > base) check("csum_ok_write", 64'(wr_q[base]), 64'({15'd0, 20'h00001}));

      stream = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFF};
      base = wr_q.size();
      run_stream("csum_bad", 1'b0);
      check("csum_bad_status", 64'({done, error, cpu_hold, busy}), 64'(4'b0110));
      check("csum_bad_nwrites", 64'(wr_q.size() - base), 64'd1);
      if (wr_q.size() > base) check("csum_bad_write", 64'(wr_q[base]), 64'({15'd0, 20'h00001}));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
